itof: RTL and testbench
=======================

Name: itof

Overview:
- Pipelined signed 32-bit integer to IEEE-754 single-precision converter; the inverse of the FPU's ftoi.
- Rounding is round-to-nearest, ties-to-even.
- Fully pipelined: accepts one operand per cycle, fixed latency, valid bit travels alongside the data.
- Sits in the FPU datapath next to ftoi and is used by the core's int-to-float (fcvt.s.w-class) instruction.

Parameters:
- NSTAGE, 3, total latency in cycles. Legal values are >= 3. Stages beyond 3 are pure delay registers appended after the pack stage.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rstn  input  1  synchronous active-low reset
- x  input  32  signed two's-complement integer operand
- x_valid  input  1  x is valid this cycle
- y  output  32  IEEE-754 single result {sign, exp[7:0], man[22:0]}
- y_valid  output  1  y is valid this cycle

Behaviour:
- Reset: when rstn=0 at a rising edge, all pipeline valid bits clear and all data registers clear. y=32'h0 and y_valid=0 from the next cycle until new data drains through.
- Reset asserted mid-stream discards every in-flight operand; none reappears after rstn returns to 1.
- Latency and throughput:
  - A sample {x, x_valid} taken at edge k appears on {y, y_valid} after edge k+NSTAGE-1. That is, y is registered NSTAGE cycles after x is presented.
  - No stall. Throughput is one operand per cycle. Bubbles (x_valid=0) propagate as y_valid=0.
- y holds the last valid result while y_valid=0; the bench checks y only when y_valid=1.
- Stage 1 (sign/magnitude):
  - s = x[31]; mag = s ? -x : x, computed as a 32-bit unsigned value.
  - x = 32'h80000000 gives mag = 32'h80000000 with no overflow, because mag is treated as unsigned.
  - Register s, mag, and zero = (x==0).
- Stage 2 (normalize):
  - lz = leading-zero count of mag, range 0..31 (lz is don't-care when zero=1).
  - norm = mag << lz, so norm[31]=1 for nonzero inputs.
  - e = 158 - lz, i.e. 127 + 31 - lz, 8-bit.
  - Register s, zero, e, norm.
- Stage 3 (round/pack):
  - man24 = norm[31:8], guard g = norm[7], sticky st = |norm[6:0], lsb = norm[8].
  - Round up when g & (st | lsb).
  - The 25-bit sum man24+1 carries out when man24 = 24'hFFFFFF. On carry, set man = 0 and e = e+1.
  - e never exceeds 158, so no overflow or infinity case exists.
  - Inputs with |x| < 2^24 are exact: g = st = 0.
  - Output y = zero ? 32'h00000000 : {s, e, man[22:0]}. The result is never -0.
- y_valid follows x_valid through the same NSTAGE-deep shift chain, with the same reset.
- No exceptions or flags; every integer maps to a finite normal or +0.

Decomposition:
- Shared package fpu_pkg:
  - BIAS=127, EXP_W=8, MAN_W=23
  - typedef float_t as a packed struct {sign, exp, man}
  - INT_EXP_BASE=158
- These are shared with ftoi and the rest of the FPU.
- One sub-module: lzc32, a combinational 32-bit leading-zero counter with output lz[4:0] and all_zero. It is instantiated in stage 2 and is reusable by fadd normalization.

Test Plan:
- Reset/zero: hold rstn=0 for 2 cycles -> y=0, y_valid=0. Then x=0, valid=1 -> NSTAGE cycles later y=32'h00000000.
- Small exact values: x=1 -> 32'h3F800000; x=-1 -> 32'hBF800000; x=16777216 -> 32'h4B800000; x=-123456 -> 32'hC7F12000.
- Rounding ties and carry:
  - x=16777217 -> 32'h4B800000 (tie, round to even, down)
  - x=16777219 -> 32'h4B800002 (tie, round up)
  - x=16777223 -> 32'h4B800004 (tie, round up)
  - x=32'h7FFFFFFF -> 32'h4F000000 (mantissa carry, exponent 158)
- Extremes: x=32'h80000000 -> 32'hCF000000; x=32'h7FFFFF80 -> 32'h4EFFFFFF; x=32'h7FFFFFC0 -> 32'h4F000000.
- Streaming: 100 back-to-back $urandom operands with random x_valid bubbles -> each valid output equals $shortrealtobits of the input converted to shortreal, in order, with exactly NSTAGE latency; y_valid pattern equals x_valid delayed by NSTAGE.
- Reset mid-stream: pull rstn=0 for 1 cycle while 3 operands are in flight -> y_valid stays 0 for those operands; an operand presented after reset releases emerges with correct value and latency.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU constants and the single-precision field layout.
// Used by itof, ftoi and the rest of the FPU datapath.
package fpu_pkg;

  localparam int unsigned BIAS         = 127;
  localparam int unsigned EXP_W        = 8;
  localparam int unsigned MAN_W        = 23;
  // Exponent of a value whose leading one sits at bit 31 of a 32-bit integer.
  localparam int unsigned INT_EXP_BASE = BIAS + 31;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } float_t;

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter.
// lz is 0 when a is all zero; all_zero flags that case.
module lzc32 (
  input  logic [31:0] a,
  output logic [4:0]  lz,
  output logic        all_zero
);

  logic found;

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found && a[i]) begin
        lz    = 5'(31 - i);
        found = 1'b1;
      end
    end
  end

  assign all_zero = ~|a;

endmodule

// File: rtl/itof.sv
// Pipelined signed 32-bit integer to IEEE-754 single converter, RNE rounding.
// Stages: sign/magnitude, normalize, round/pack, then NSTAGE-3 delay registers.
module itof
  import fpu_pkg::*;
#(
  parameter int unsigned NSTAGE = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x,
  input  logic        x_valid,
  output logic [31:0] y,
  output logic        y_valid
);

  // Stage 1: sign / magnitude
  logic        s1_q, zero1_q, v1_q;
  logic [31:0] mag1_q, mag_d;

  // Unsigned negate, so 32'h80000000 maps to itself.
  assign mag_d = x[31] ? (~x + 32'd1) : x;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_q    <= 1'b0;
      zero1_q <= 1'b0;
      mag1_q  <= '0;
      v1_q    <= 1'b0;
    end else begin
      v1_q <= x_valid;
      if (x_valid) begin
        s1_q    <= x[31];
        zero1_q <= (x == 32'd0);
        mag1_q  <= mag_d;
      end
    end
  end

  // Stage 2: normalize
  logic             s2_q, zero2_q, v2_q;
  logic [EXP_W-1:0] e2_q;
  logic [31:0]      norm2_q;
  logic [4:0]       lz;
  logic             lz_all_zero;

  lzc32 u_lzc (
    .a        (mag1_q),
    .lz       (lz),
    .all_zero (lz_all_zero)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s2_q    <= 1'b0;
      zero2_q <= 1'b0;
      e2_q    <= '0;
      norm2_q <= '0;
      v2_q    <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        s2_q    <= s1_q;
        zero2_q <= zero1_q | lz_all_zero;
        e2_q    <= EXP_W'(INT_EXP_BASE - 32'(lz));
        norm2_q <= mag1_q << lz;
      end
    end
  end

  // Stage 3: round to nearest even and pack
  logic [23:0]      man24;
  logic             rnd_up;
  logic [24:0]      sum25;
  logic [EXP_W-1:0] e3;
  logic [MAN_W-1:0] man3;
  float_t           res;

  assign man24  = norm2_q[31:8];
  assign rnd_up = norm2_q[7] & ((|norm2_q[6:0]) | norm2_q[8]);
  assign sum25  = {1'b0, man24} + 25'(rnd_up);

  always_comb begin
    e3   = e2_q;
    man3 = sum25[MAN_W-1:0];
    // Carry out of the hidden bit renormalizes to 1.0 x 2^(e+1).
    if (sum25[24]) begin
      e3   = e2_q + 8'd1;
      man3 = '0;
    end
    res = '{sign: s2_q, exp: e3, man: man3};
    if (zero2_q) begin
      res = '0;
    end
  end

  logic [31:0] y3_q;
  logic        v3_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      y3_q <= '0;
      v3_q <= 1'b0;
    end else begin
      v3_q <= v2_q;
      if (v2_q) begin
        y3_q <= res;
      end
    end
  end

  // Optional pure-delay tail
  if (NSTAGE > 3) begin : g_delay
    localparam int unsigned Extra = NSTAGE - 3;
    logic [31:0] dly_q [Extra];
    logic        dv_q  [Extra];

    always_ff @(posedge clk) begin
      if (!rstn) begin
        for (int i = 0; i < int'(Extra); i++) begin
          dly_q[i] <= '0;
          dv_q[i]  <= 1'b0;
        end
      end else begin
        dv_q[0] <= v3_q;
        if (v3_q) begin
          dly_q[0] <= y3_q;
        end
        for (int i = 1; i < int'(Extra); i++) begin
          dv_q[i] <= dv_q[i-1];
          if (dv_q[i-1]) begin
            dly_q[i] <= dly_q[i-1];
          end
        end
      end
    end

    assign y       = dly_q[Extra-1];
    assign y_valid = dv_q[Extra-1];
  end else begin : g_nodelay
    assign y       = y3_q;
    assign y_valid = v3_q;
  end

endmodule

// File: tb/tb_itof.sv
// Self-checking bench for itof: directed vectors, random streaming, mid-stream reset.
module tb_itof;

  localparam int unsigned NSTAGE = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] x;
  logic        x_valid;
  logic [31:0] y;
  logic        y_valid;

  int n_checks = 0;
  int n_fail   = 0;

  itof #(.NSTAGE(NSTAGE)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .x       (x),
    .x_valid (x_valid),
    .y       (y),
    .y_valid (y_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] xin;
    logic [31:0] yexp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Reference: exact integer magnitude, round by comparing the dropped remainder with one half.
  function automatic logic [31:0] ref_itof(input logic [31:0] xi);
    logic [63:0] m, q, rem, half;
    int          p, sh;
    logic        s;
    s = xi[31];
    m = s ? 64'(-{32'h0, xi}) & 64'hFFFF_FFFF : {32'h0, xi};
    if (m == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 64; i++) if (m[i]) p = i;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q = 64'd1 << 23;
        p = p + 1;
      end
    end
    return {s, 8'(p + 127), q[22:0]};
  endfunction

  // Present one operand and check y_valid timing and value at exactly NSTAGE edges later.
  task automatic run_one(input string name, input logic [31:0] xi, input logic [31:0] yexp);
    @(negedge clk);
    x       = xi;
    x_valid = 1'b1;
    @(negedge clk);
    x_valid = 1'b0;
    repeat (NSTAGE - 2) @(negedge clk);
    check({name, " early_valid"}, {31'h0, y_valid}, 32'h0);
    @(negedge clk);
    check({name, " valid"}, {31'h0, y_valid}, 32'h1);
    check(name, y, yexp);
  endtask

  vec_t        vecs[$];
  logic [31:0] in_x[$];
  logic        in_v[$];

  initial begin
    rstn    = 1'b0;
    x       = '0;
    x_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset y", y, 32'h0);
    check("reset y_valid", {31'h0, y_valid}, 32'h0);
    rstn = 1'b1;

    vecs = '{
      '{32'h0000_0000, 32'h0000_0000},
      '{32'd1,         32'h3F80_0000},
      '{32'hFFFF_FFFF, 32'hBF80_0000},
      '{32'd16777216,  32'h4B80_0000},
      '{-32'sd123456,  32'hC7F1_2000},
      '{32'd16777217,  32'h4B80_0000},
      '{32'd16777219,  32'h4B80_0002},
      '{32'd16777223,  32'h4B80_0004},
      '{32'h7FFF_FFFF, 32'h4F00_0000},
      '{32'h8000_0000, 32'hCF00_0000},
      '{32'h7FFF_FF80, 32'h4EFF_FFFF},
      '{32'h7FFF_FFC0, 32'h4F00_0000}
    };
    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("vec%0d x=%08h", i, vecs[i].xin);
      run_one(nm, vecs[i].xin, vecs[i].yexp);
    end

    // Random streaming with bubbles; compare against inputs delayed by NSTAGE.
    repeat (NSTAGE + 2) @(negedge clk);
    for (int c = 0; c < 100 + int'(NSTAGE); c++) begin
      @(negedge clk);
      if (c >= int'(NSTAGE)) begin
        logic [31:0] ex;
        logic        ev;
        ex = in_x.pop_front();
        ev = in_v.pop_front();
        check($sformatf("stream%0d y_valid", c), {31'h0, y_valid}, {31'h0, ev});
        if (ev) check($sformatf("stream%0d x=%08h", c, ex), y, ref_itof(ex));
      end
      if (c < 100) begin
        logic [31:0] r;
        r = $urandom() >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) r = -r;
        x       = r;
        x_valid = ($urandom_range(0, 3) != 0);
      end else begin
        x_valid = 1'b0;
      end
      in_x.push_back(x);
      in_v.push_back(x_valid);
    end
    x_valid = 1'b0;

    // Mid-stream reset: three operands in flight are discarded.
    repeat (NSTAGE + 2) @(negedge clk);
    x = 32'd5;  x_valid = 1'b1;
    @(negedge clk);
    x = 32'd6;
    @(negedge clk);
    x = 32'd7;  rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1; x_valid = 1'b0;
    for (int k = 0; k < int'(NSTAGE) + 2; k++) begin
      check($sformatf("flush%0d y_valid", k), {31'h0, y_valid}, 32'h0);
      check($sformatf("flush%0d y", k), y, 32'h0);
      @(negedge clk);
    end
    run_one("post_reset x=-2", 32'hFFFF_FFFE, 32'hC000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
